// File: rtl/encoder_4to2_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared widths, FSM state encoding and a decode helper for the
//               serial 4-to-2 priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

  // Number of request lines (only 4 is supported) and encoded index width
  localparam int N_IN   = 4;
  localparam int CODE_W = $clog2(N_IN);

  // Two-state controller: waiting for a vector, or draining pending bits
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One-hot bit corresponding to an encoded index; used to clear a popped bit
  function automatic logic [N_IN-1:0] idx_to_bit(input logic [CODE_W-1:0] idx);
    logic [N_IN-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/encoder_4to2_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : encoder_4to2_serial_if
// Description : Request-side and output-side handshake bundle of the serial
//               4-to-2 encoder. The encoder takes the slave view.
// Revision    : 1.0 - initial release
// ============================================================================
interface encoder_4to2_serial_if;
  import enc_pkg::*;

  logic [N_IN-1:0]   req_in;
  logic              req_valid;
  logic              req_ready;
  logic [CODE_W-1:0] enc_out;
  logic              out_valid;
  logic              out_ready;
  logic              enc_last;
  logic              zero_err;

  // Producer/consumer side (drives requests, accepts indices)
  modport master (
    output req_in, req_valid, out_ready,
    input  req_ready, enc_out, out_valid, enc_last, zero_err
  );

  // Encoder side
  modport slave (
    input  req_in, req_valid, out_ready,
    output req_ready, enc_out, out_valid, enc_last, zero_err
  );

endinterface
`default_nettype wire

// File: rtl/encoder_4to2_serial_pri_enc4.sv
`default_nettype none
// ============================================================================
// Module      : pri_enc4
// Description : Combinational MSB-first priority encoder over the pending
//               mask. Reports the highest set index, whether exactly one bit
//               is set, and whether any bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module pri_enc4
  import enc_pkg::*;
(
  input  wire logic [N_IN-1:0]   mask,
  output logic      [CODE_W-1:0] idx,
  output logic                   last,
  output logic                   any
);

  logic [N_IN-1:0] w_rest;

  // Highest set bit wins; an empty mask decodes to index 0
  always_comb begin
    idx = '0;
    if (mask[3])      idx = 2'd3;
    else if (mask[2]) idx = 2'd2;
    else if (mask[1]) idx = 2'd1;
    else              idx = 2'd0;
  end

  // Clearing the lowest set bit leaves zero only when a single bit was set
  always_comb begin
    w_rest = mask & (mask - 1'b1);
    any    = |mask;
    last   = any && (w_rest == '0);
  end

endmodule
`default_nettype wire

// File: rtl/encoder_4to2_serial.sv
`default_nettype none
// ============================================================================
// Module      : encoder_4to2_serial
// Description : Accepts a request vector and emits the index of every set bit,
//               one per handshake, highest bit first. An all-zero vector is
//               rejected with a one-cycle zero_err pulse. All outputs are
//               decoded from registered state.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_4to2_serial #(
  parameter int N_IN   = 4,
  parameter int CODE_W = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  encoder_4to2_serial_if.slave  bus
);
  import enc_pkg::*;

  state_t              r_state;
  logic [N_IN-1:0]     r_mask;
  logic                r_zero_err;
  // Low throughout reset and set on the first edge after release, so the
  // block refuses requests until it has seen one clean clock.
  logic                r_live;

  logic [CODE_W-1:0]   w_idx;
  logic                w_last;
  logic                w_any;
  logic [N_IN-1:0]     w_pop_bit;

  pri_enc4 u_pri_enc4 (
    .mask (r_mask),
    .idx  (w_idx),
    .last (w_last),
    .any  (w_any)
  );

  assign w_pop_bit = idx_to_bit(w_idx);

  // Controller: accept vectors in IDLE, drain the mask one bit per pop in BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mask     <= '0;
      r_zero_err <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_live     <= 1'b1;
      r_zero_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_live && bus.req_valid) begin
            if (bus.req_in == '0) begin
              r_zero_err <= 1'b1;
            end else begin
              r_mask  <= bus.req_in;
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.out_ready) begin
            r_mask <= r_mask & ~w_pop_bit;
            // An empty mask in BUSY cannot arise normally; leaving is the
            // safe recovery rather than presenting a phantom index.
            if (w_last || !w_any) begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_mask  <= '0;
        end
      endcase
    end
  end

  // The mask is empty in IDLE, so enc_out/enc_last read 00/0 there
  assign bus.req_ready = r_live && (r_state == IDLE);
  assign bus.out_valid = (r_state == BUSY);
  assign bus.enc_out   = w_idx;
  assign bus.enc_last  = w_last;
  assign bus.zero_err  = r_zero_err;

endmodule
`default_nettype wire

// File: tb/tb_encoder_4to2_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_4to2_serial
// Description : Directed and randomized self-checking bench for the serial
//               4-to-2 priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_4to2_serial;
  import enc_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  encoder_4to2_serial_if bus ();

  encoder_4to2_serial #(.N_IN(4), .CODE_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the full output bundle against a hand-computed expectation
  task automatic chk(input string tag, input logic rdy, input logic vld,
                     input logic [1:0] enc, input logic last, input logic zerr);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {bus.req_ready, bus.out_valid, bus.enc_out, bus.enc_last, bus.zero_err};
    exp = {rdy, vld, enc, last, zerr};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed rdy/vld/enc/last/zerr=%b required %b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] highest(input logic [3:0] m);
    logic [1:0] h;
    h = 2'd0;
    for (int i = 0; i < 4; i++) if (m[i]) h = 2'(i);
    return h;
  endfunction

  initial begin
    logic [3:0] vec;
    logic [3:0] rem;
    logic [3:0] got;
    logic [1:0] seen;
    logic       rdy;
    n_tests = 0;
    n_fail  = 0;
    rst_n         = 1'b0;
    bus.req_in    = 4'b0000;
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held: everything at reset values, not ready
    tick(); tick();
    chk("reset_hold", 0, 0, 2'd0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("reset_release_pre_edge", 0, 0, 2'd0, 0, 0);
    tick();
    chk("ready_after_release", 1, 0, 2'd0, 0, 0);

    // Single beat 0100 -> 10 last
    bus.req_in = 4'b0100; bus.req_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    chk("v0100_beat", 0, 1, 2'd2, 1, 0);
    bus.req_valid = 1'b0;
    tick();
    chk("v0100_idle", 1, 0, 2'd0, 0, 0);

    // 1011 -> 11, 01, 00(last)
    bus.req_in = 4'b1011; bus.req_valid = 1'b1;
    tick();
    chk("v1011_b0", 0, 1, 2'd3, 0, 0);
    bus.req_valid = 1'b0;
    tick();
    chk("v1011_b1", 0, 1, 2'd1, 0, 0);
    tick();
    chk("v1011_b2", 0, 1, 2'd0, 1, 0);
    tick();
    chk("v1011_idle", 1, 0, 2'd0, 0, 0);

    // 1111 with stall, then drain 11,10,01,00
    bus.req_in = 4'b1111; bus.req_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    chk("v1111_present", 0, 1, 2'd3, 0, 0);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("v1111_stall", 0, 1, 2'd3, 0, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("v1111_b1", 0, 1, 2'd2, 0, 0);
    tick();
    chk("v1111_b2", 0, 1, 2'd1, 0, 0);
    tick();
    chk("v1111_b3", 0, 1, 2'd0, 1, 0);
    tick();
    chk("v1111_idle", 1, 0, 2'd0, 0, 0);

    // All-zero vector: one-cycle zero_err, stay ready
    bus.req_in = 4'b0000; bus.req_valid = 1'b1;
    tick();
    chk("zero_pulse", 1, 0, 2'd0, 0, 1);
    bus.req_valid = 1'b0;
    tick();
    chk("zero_clear", 1, 0, 2'd0, 0, 0);

    // 0110, reset after first pop discards the remaining bit
    bus.req_in = 4'b0110; bus.req_valid = 1'b1;
    tick();
    chk("v0110_b0", 0, 1, 2'd2, 0, 0);
    bus.req_valid = 1'b0;
    tick();
    chk("v0110_b1", 0, 1, 2'd1, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 0, 0, 2'd0, 0, 0);
    tick();
    chk("reset_busy_hold", 0, 0, 2'd0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", 1, 0, 2'd0, 0, 0);
    tick();
    chk("post_reset_no_beat", 1, 0, 2'd0, 0, 0);
    bus.req_in = 4'b0001; bus.req_valid = 1'b1;
    tick();
    chk("v0001_beat", 0, 1, 2'd0, 1, 0);
    bus.req_valid = 1'b0;
    tick();
    chk("v0001_idle", 1, 0, 2'd0, 0, 0);

    // New vector held on req_valid during BUSY is taken one cycle after last pop
    bus.req_in = 4'b1010; bus.req_valid = 1'b1;
    tick();
    chk("hold_b0", 0, 1, 2'd3, 0, 0);
    bus.req_in = 4'b0101;
    tick();
    chk("hold_b1", 0, 1, 2'd1, 1, 0);
    tick();
    chk("hold_gap", 1, 0, 2'd0, 0, 0);
    tick();
    chk("hold_next_b0", 0, 1, 2'd2, 0, 0);
    bus.req_valid = 1'b0;
    tick();
    chk("hold_next_b1", 0, 1, 2'd0, 1, 0);
    tick();
    chk("hold_next_idle", 1, 0, 2'd0, 0, 0);

    // Randomized vectors with random back-pressure
    for (int v = 0; v < 10; v++) begin
      vec = 4'($urandom_range(1, 15));
      rem = vec;
      got = 4'b0000;
      bus.req_in = vec; bus.req_valid = 1'b1; bus.out_ready = 1'b0;
      tick();
      bus.req_valid = 1'b0;
      for (int c = 0; c < 40 && rem != 4'b0000; c++) begin
        chk("rnd_present", 0, 1, highest(rem), ($countones(rem) == 1), 0);
        rdy = 1'($urandom_range(0, 1));
        bus.out_ready = rdy;
        seen = bus.enc_out;
        tick();
        if (rdy) begin
          chk_val("rnd_no_dup", {7'd0, got[seen]}, 8'd0);
          got[seen] = 1'b1;
          rem[highest(rem)] = 1'b0;
        end
      end
      chk_val("rnd_multiset", {4'd0, got}, {4'd0, vec});
      chk("rnd_idle", 1, 0, 2'd0, 0, 0);
      bus.out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
